tt_bit_column: RTL and testbench

Parametrised, clocked column of WIDTH Turing Tumble bit pieces chained as a marble-driven binary counter. A marble dropped on top toggles bit 0. If that bit was 1 before the toggle, the marble carries to the next bit; otherwise it leaves the column at that stage. Carries are pipelined one stage per clock, so a new marble can be accepted every cycle. The block adds gear-style parallel load, a completed-marble counter and an interceptor-style overflow halt.

---
 rtl/tt_pkg.sv | 25 ++
 rtl/tt_bit_stage.sv | 44 ++++
 rtl/tt_bit_column.sv | 80 ++++++++
 tb/tb_tt_bit_column.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and helpers for the Turing Tumble bit column.
// Counter arithmetic never wraps: it saturates at all-ones.
package tt_pkg;

  localparam int MARBLE_CNT_W = 16;
  localparam int POP_MAX_W    = 64;

  typedef logic [MARBLE_CNT_W-1:0] marble_cnt_t;

  function automatic marble_cnt_t popcount(input logic [POP_MAX_W-1:0] x);
    marble_cnt_t n;
    n = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + {{(MARBLE_CNT_W-1){1'b0}}, x[i]};
    end
    return n;
  endfunction

  function automatic marble_cnt_t sat_add16(input marble_cnt_t a, input marble_cnt_t b);
    logic [MARBLE_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[MARBLE_CNT_W] ? '1 : sum[MARBLE_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/tt_bit_stage.sv
// One bit piece: a marble toggles the bit and carries on only if the bit was 1.
// Stage 0 has no token register; its marble arrives straight from the drop input.
module tt_bit_stage
  import tt_pkg::*;
#(
  parameter bit INIT_BIT  = 1'b0,
  parameter bit REG_TOKEN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic token_in,
  input  logic load,
  input  logic load_bit,
  output logic bit_q,
  output logic token_q,
  output logic carry_out,
  output logic exit_out
);

  logic bit_r;
  logic tok_r;
  logic active;

  assign active    = REG_TOKEN ? tok_r : token_in;
  assign carry_out = active & bit_r;
  assign exit_out  = active & ~bit_r;
  assign bit_q     = bit_r;
  assign token_q   = REG_TOKEN ? tok_r : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_r <= INIT_BIT;
      tok_r <= 1'b0;
    end else begin
      tok_r <= REG_TOKEN ? token_in : 1'b0;
      if (load) begin
        bit_r <= load_bit;
      end else if (active) begin
        bit_r <= ~bit_r;
      end
    end
  end

endmodule

// File: rtl/tt_bit_column.sv
// Pipelined column of WIDTH bit pieces forming a marble-driven binary counter,
// with gear load, a saturating completed-marble counter and an overflow halt.
module tt_bit_column
  import tt_pkg::*;
#(
  parameter int              WIDTH            = 4,
  parameter logic [WIDTH-1:0] INIT            = {WIDTH{1'b0}},
  parameter bit              STOP_ON_OVERFLOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_drop,
  output logic                    o_ready,
  input  logic                    i_load,
  input  logic [WIDTH-1:0]        i_load_value,
  output logic [WIDTH-1:0]        o_value,
  output logic [WIDTH-1:0]        o_exit,
  output logic                    o_overflow,
  output logic                    o_busy,
  output logic                    o_halted,
  output logic [MARBLE_CNT_W-1:0] o_marbles
);

  logic             accept;
  logic             load_apply;
  logic             overflow_next;
  logic [WIDTH-1:0] token_in;
  logic [WIDTH-1:0] token_q;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] exit_next;
  marble_cnt_t      completed;

  assign o_ready    = ~o_halted & ~i_load;
  assign accept     = i_drop & o_ready;
  // Loading mid-flight would corrupt the in-flight increments, so it waits for idle.
  assign load_apply = i_load & ~o_busy;
  assign o_busy     = |token_q;

  assign token_in[0]   = accept;
  assign overflow_next = carry[WIDTH-1];

  for (genvar s = 1; s < WIDTH; s++) begin : g_chain
    assign token_in[s] = carry[s-1];
  end

  for (genvar s = 0; s < WIDTH; s++) begin : g_stage
    tt_bit_stage #(
      .INIT_BIT (INIT[s]),
      .REG_TOKEN(s != 0)
    ) u_stage (
      .clk      (i_clk),
      .rst      (i_rst),
      .token_in (token_in[s]),
      .load     (load_apply),
      .load_bit (i_load_value[s]),
      .bit_q    (o_value[s]),
      .token_q  (token_q[s]),
      .carry_out(carry[s]),
      .exit_out (exit_next[s])
    );
  end

  assign completed = popcount(POP_MAX_W'(exit_next))
                   + {{(MARBLE_CNT_W-1){1'b0}}, overflow_next};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_exit     <= '0;
      o_overflow <= 1'b0;
      o_halted   <= 1'b0;
      o_marbles  <= '0;
    end else begin
      o_exit     <= exit_next;
      o_overflow <= overflow_next;
      o_halted   <= o_halted | (STOP_ON_OVERFLOW & overflow_next);
      o_marbles  <= sat_add16(o_marbles, completed);
    end
  end

endmodule

// File: tb/tb_tt_bit_column.sv
// Bench for tt_bit_column: directed vector table, an overflow/halt sequence and
// randomized traffic checked against an event-scheduled counter model.
module tb_tt_bit_column;
  import tt_pkg::*;

  localparam int             W      = 4;
  localparam logic [W-1:0]   INIT_V = 4'b0111;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         drop = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         ready;
  logic [W-1:0] value;
  logic [W-1:0] exit_v;
  logic         ovf;
  logic         busy;
  logic         halted;
  logic [15:0]  marbles;

  int n_vec = 0;
  int n_bad = 0;
  int ovf_pulses = 0;

  always #5 clk = ~clk;

  tt_bit_column #(
    .WIDTH(W),
    .INIT(INIT_V),
    .STOP_ON_OVERFLOW(1'b1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_drop(drop),
    .o_ready(ready),
    .i_load(load),
    .i_load_value(load_value),
    .o_value(value),
    .o_exit(exit_v),
    .o_overflow(ovf),
    .o_busy(busy),
    .o_halted(halted),
    .o_marbles(marbles)
  );

  // Reference model: each accepted marble is a sequential increment whose bit
  // toggles and exit/overflow pulse are scheduled at absolute edge numbers.
  int           edge_no = 0;
  int           m_busy_until;
  logic [W-1:0] m_logical;
  logic [W-1:0] m_value;
  logic [W-1:0] m_exit;
  logic         m_ovf;
  logic         m_halted;
  logic [15:0]  m_marbles;
  logic [W-1:0] m_tog    [64];
  logic [W-1:0] m_exit_s [64];
  logic         m_ovf_s  [64];

  function automatic logic m_busy();
    return m_busy_until >= edge_no;
  endfunction

  task automatic modelReset();
    m_logical    = INIT_V;
    m_value      = INIT_V;
    m_exit       = '0;
    m_ovf        = 1'b0;
    m_halted     = 1'b0;
    m_marbles    = '0;
    m_busy_until = -1;
    for (int i = 0; i < 64; i++) begin
      m_tog[i]    = '0;
      m_exit_s[i] = '0;
      m_ovf_s[i]  = 1'b0;
    end
  endtask

  task automatic modelEdge(input logic accept, input logic load_apply, input logic [W-1:0] lv);
    int e;
    int idx;
    int s;
    int last;
    int total;
    e = edge_no;
    if (accept) begin
      s = 0;
      while (s < W && m_logical[s]) s++;
      for (int k = 0; k < W && k <= s; k++) begin
        m_tog[(e + k) % 64][k] = ~m_tog[(e + k) % 64][k];
      end
      if (s < W) begin
        m_exit_s[(e + s) % 64][s] = 1'b1;
        last = e + s;
      end else begin
        m_ovf_s[(e + W - 1) % 64] = 1'b1;
        last = e + W - 1;
      end
      if (last > m_busy_until) m_busy_until = last;
      m_logical = m_logical + 1'b1;
    end
    if (load_apply) begin
      m_logical = lv;
      m_value   = lv;
    end
    idx          = e % 64;
    m_value      = m_value ^ m_tog[idx];
    m_exit       = m_exit_s[idx];
    m_ovf        = m_ovf_s[idx];
    m_tog[idx]    = '0;
    m_exit_s[idx] = '0;
    m_ovf_s[idx]  = 1'b0;
    total = int'(m_marbles) + int'(m_ovf);
    for (int b = 0; b < W; b++) total += int'(m_exit[b]);
    m_marbles = (total > 65535) ? 16'hFFFF : total[15:0];
    m_halted  = m_halted | m_ovf;
    edge_no++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("value",    32'(value),   32'(m_value));
    checkOutput("exit",     32'(exit_v),  32'(m_exit));
    checkOutput("overflow", 32'(ovf),     32'(m_ovf));
    checkOutput("busy",     32'(busy),    32'(m_busy()));
    checkOutput("halted",   32'(halted),  32'(m_halted));
    checkOutput("marbles",  32'(marbles), 32'(m_marbles));
  endtask

  // Called with the clock low; leaves the clock low again.
  task automatic applyStimulus(input logic d, input logic l, input logic [W-1:0] lv);
    logic m_ready;
    logic acc;
    logic lapp;
    drop       = d;
    load       = l;
    load_value = lv;
    #1;
    m_ready = ~m_halted & ~l;
    checkOutput("ready", 32'(ready), 32'(m_ready));
    acc  = d & m_ready;
    lapp = l & ~m_busy();
    @(posedge clk);
    modelEdge(acc, lapp, lv);
    #1;
    if (ovf === 1'b1) ovf_pulses++;
    checkModel();
    @(negedge clk);
  endtask

  task automatic doReset();
    drop = 1'b0;
    load = 1'b0;
    rst  = 1'b1;
    #1;
    modelReset();
    checkModel();
    checkOutput("reset_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    checkModel();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic         rst;
    logic         drop;
    logic         load;
    logic [W-1:0] lv;
    logic [W-1:0] e_value;
    logic [W-1:0] e_exit;
    logic         e_busy;
    logic [15:0]  e_marbles;
  } vec_t;

  vec_t tbl [23];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0001, 1'b0, 16'd1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 16'd1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'b0111, 4'b0111, 4'b0000, 1'b0, 16'd1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0110, 4'b0000, 1'b1, 16'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b1, 16'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 16'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'b1000, 1'b0, 16'd2};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'b0000, 1'b0, 16'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 16'd2};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 16'd2};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0011, 4'b0011, 1'b0, 16'd4};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011, 4'b0000, 1'b0, 16'd4};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 4'b0111, 4'b0111, 4'b0000, 1'b0, 16'd4};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0110, 4'b0000, 1'b1, 16'd4};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 4'b1010, 4'b0100, 4'b0000, 1'b1, 16'd4};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 4'b1010, 4'b0000, 4'b0000, 1'b1, 16'd4};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'b1000, 1'b0, 16'd5};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 4'b1010, 4'b1010, 4'b0000, 1'b0, 16'd5};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 4'b0111, 4'b0111, 4'b0000, 1'b0, 16'd5};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0110, 4'b0000, 1'b1, 16'd5};
    tbl[21] = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0111, 4'b0000, 1'b0, 16'd0};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0111, 4'b0000, 1'b0, 16'd0};

    modelReset();
    @(negedge clk);
    doReset();
    checkOutput("reset_value", 32'(value), 32'(INIT_V));

    for (int i = 0; i < 23; i++) begin
      if (tbl[i].rst) doReset();
      else applyStimulus(tbl[i].drop, tbl[i].load, tbl[i].lv);
      checkOutput($sformatf("row%0d_value", i),   32'(value),   32'(tbl[i].e_value));
      checkOutput($sformatf("row%0d_exit", i),    32'(exit_v),  32'(tbl[i].e_exit));
      checkOutput($sformatf("row%0d_busy", i),    32'(busy),    32'(tbl[i].e_busy));
      checkOutput($sformatf("row%0d_marbles", i), 32'(marbles), 32'(tbl[i].e_marbles));
      checkOutput($sformatf("row%0d_ovf", i),     32'(ovf),     32'd0);
    end

    // Sixteen back-to-back marbles from zero wrap the column exactly once.
    applyStimulus(1'b0, 1'b1, 4'b0000);
    ovf_pulses = 0;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 8 && busy; i++) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("drain_bound", 32'(busy), 32'd0);
    checkOutput("ovf_pulses", 32'(ovf_pulses), 32'd1);
    checkOutput("ovf_halted", 32'(halted), 32'd1);
    checkOutput("ovf_value", 32'(value), 32'd0);
    checkOutput("ovf_marbles", 32'(marbles), 32'd16);
    checkOutput("ovf_ready", 32'(ready), 32'd0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("drop17_value", 32'(value), 32'd0);
    checkOutput("drop17_marbles", 32'(marbles), 32'd16);
    applyStimulus(1'b0, 1'b1, 4'b0101);
    checkOutput("load_halted_value", 32'(value), 32'b0101);
    checkOutput("load_keeps_halt", 32'(halted), 32'd1);

    checkOutput("sat_small", 32'(sat_add16(16'd10, 16'd3)), 32'd13);
    checkOutput("sat_edge", 32'(sat_add16(16'hFFFE, 16'd2)), 32'hFFFF);
    checkOutput("sat_full", 32'(sat_add16(16'hFFFF, 16'd0)), 32'hFFFF);

    doReset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 2) doReset();
      else applyStimulus(($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 8), W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
